// File: rtl/dmem_responder_if.sv
// Load/store bus between the CPU (master) and the data-memory responder (slave).
// The CPU holds req high with stable fields until it sees the one-cycle ack.
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [2:0]  funct3;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        fault;

  modport master (
    output req, we, addr, funct3, wdata,
    input  ack, rdata, fault
  );

  modport slave (
    input  req, we, addr, funct3, wdata,
    output ack, rdata, fault
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_STATES wait cycles, then a
// single-cycle registered response. Byte/half/word accesses use RISC-V funct3.
// Optional macro DMEM_ALIGN_CHECK_EN: misaligned half/word accesses fault instead
// of having their low address bits ignored.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam int unsigned Depth    = 1 << ADDR_WIDTH;
  localparam logic [3:0]  WaitLast = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StRespond} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;

  logic [31:0] mem [Depth];

  // In IDLE the access may execute on the accepting edge (WAIT_STATES=0), so
  // use the live bus fields there and the latched copies otherwise.
  logic                  use_bus;
  logic                  cur_we;
  logic [31:0]           cur_addr;
  logic [2:0]            cur_funct3;
  logic [31:0]           cur_wdata;
  logic                  exec;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           rd_word;
  logic [31:0]           rd_shift;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;
  logic [3:0]            be;
  logic [31:0]           wd;
  logic [31:0]           ld_val;
  logic                  illegal;

  assign use_bus    = (state_q == StIdle);
  assign cur_we     = use_bus ? bus.we     : we_q;
  assign cur_addr   = use_bus ? bus.addr   : addr_q;
  assign cur_funct3 = use_bus ? bus.funct3 : funct3_q;
  assign cur_wdata  = use_bus ? bus.wdata  : wdata_q;

  assign idx      = cur_addr[ADDR_WIDTH+1:2];
  assign rd_word  = mem[idx];
  assign rd_shift = rd_word >> {cur_addr[1:0], 3'b000};
  assign lane_b   = rd_shift[7:0];
  assign lane_h   = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];

  // Next state, wait counter and the "access executes at this edge" strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exec    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          cnt_d = '0;
          if (WAIT_STATES == 0) begin
            state_d = StRespond;
            exec    = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == WaitLast) begin
          state_d = StRespond;
          exec    = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Size/sign decode: byte enables, replicated store data, extended load value.
  always_comb begin
    illegal = 1'b0;
    be      = 4'b0000;
    wd      = cur_wdata;
    ld_val  = '0;
    case (cur_funct3)
      3'b000: begin
        be     = 4'b0001 << cur_addr[1:0];
        wd     = {4{cur_wdata[7:0]}};
        ld_val = {{24{lane_b[7]}}, lane_b};
      end
      3'b001: begin
        be     = cur_addr[1] ? 4'b1100 : 4'b0011;
        wd     = {2{cur_wdata[15:0]}};
        ld_val = {{16{lane_h[15]}}, lane_h};
      end
      3'b010: begin
        be     = 4'b1111;
        ld_val = rd_word;
      end
      3'b100: begin
        ld_val  = {24'd0, lane_b};
        illegal = cur_we;
      end
      3'b101: begin
        ld_val  = {16'd0, lane_h};
        illegal = cur_we;
      end
      default: illegal = 1'b1;
    endcase
    if ((cur_addr >> (ADDR_WIDTH + 2)) != 32'd0) begin
      illegal = 1'b1;
    end
`ifdef DMEM_ALIGN_CHECK_EN
    if ((cur_funct3[1:0] == 2'b01) && cur_addr[0]) begin
      illegal = 1'b1;
    end
    if ((cur_funct3 == 3'b010) && (cur_addr[1:0] != 2'b00)) begin
      illegal = 1'b1;
    end
`endif
  end

  // Response payload is nonzero only in the cycle ack is high.
  always_comb begin
    rdata_d = '0;
    fault_d = 1'b0;
    if (exec) begin
      fault_d = illegal;
      if (!illegal && !cur_we) begin
        rdata_d = ld_val;
      end
    end
  end

  // Control state and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  // Capture the request fields on acceptance; they need no reset.
  always_ff @(posedge clk) begin
    if (state_q == StIdle && bus.req) begin
      we_q     <= bus.we;
      addr_q   <= bus.addr;
      funct3_q <= bus.funct3;
      wdata_q  <= bus.wdata;
    end
  end

  // Byte-enabled store; the array is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && exec && cur_we && !illegal) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wd[8*i +: 8];
        end
      end
    end
  end

  assign bus.ack   = (state_q == StRespond);
  assign bus.rdata = rdata_q;
  assign bus.fault = fault_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: dut1 uses WAIT_STATES=1, dut3 uses WAIT_STATES=3.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst1 = 1'b1;
  logic rst3 = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  dmem_responder_if b1 ();
  dmem_responder_if b3 ();

  dmem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(1)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (b1.slave)
  );

  dmem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(3)) dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (b3.slave)
  );

  // One full transaction on the selected DUT; lat counts negedges until ack.
  task automatic acc(input int sel, input logic w, input logic [31:0] a,
                     input logic [2:0] f, input logic [31:0] d,
                     output logic [31:0] rd, output logic flt, output int lat);
    @(negedge clk);
    if (sel == 1) begin
      b1.req = 1'b1; b1.we = w; b1.addr = a; b1.funct3 = f; b1.wdata = d;
    end else begin
      b3.req = 1'b1; b3.we = w; b3.addr = a; b3.funct3 = f; b3.wdata = d;
    end
    lat = 0;
    rd  = 'x;
    flt = 1'bx;
    do begin
      @(negedge clk);
      lat++;
    end while (((sel == 1) ? b1.ack : b3.ack) !== 1'b1 && lat < 40);
    if (sel == 1) begin
      rd = b1.rdata; flt = b1.fault; b1.req = 1'b0;
    end else begin
      rd = b3.rdata; flt = b3.fault; b3.req = 1'b0;
    end
  endtask

  task automatic test_reset();
    b1.req = 1'b0; b1.we = 1'b0; b1.addr = '0; b1.funct3 = '0; b1.wdata = '0;
    b3.req = 1'b0; b3.we = 1'b0; b3.addr = '0; b3.funct3 = '0; b3.wdata = '0;
    rst1 = 1'b1; rst3 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst1 = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (b1.ack !== 1'b0) $display("FAIL reset_ack1: got %b want 0", b1.ack); else n_pass++;
    n_checks++;
    if (b1.rdata !== 32'd0) $display("FAIL reset_rdata1: got %h want 0", b1.rdata); else n_pass++;
    n_checks++;
    if (b1.fault !== 1'b0) $display("FAIL reset_fault1: got %b want 0", b1.fault); else n_pass++;
    n_checks++;
    if (b3.ack !== 1'b0) $display("FAIL reset_ack3: got %b want 0", b3.ack); else n_pass++;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic flt; int lat;
    acc(1, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, rd, flt, lat);
    n_checks++;
    if (lat !== 2) $display("FAIL sw_latency: got %0d want 2", lat); else n_pass++;
    n_checks++;
    if (flt !== 1'b0) $display("FAIL sw_fault: got %b want 0", flt); else n_pass++;
    acc(1, 1'b0, 32'h10, 3'b010, 32'h0, rd, flt, lat);
    n_checks++;
    if (lat !== 2) $display("FAIL lw_latency: got %0d want 2", lat); else n_pass++;
    n_checks++;
    if (rd !== 32'hDEADBEEF) $display("FAIL lw_10: got %h want DEADBEEF", rd); else n_pass++;
    n_checks++;
    if (flt !== 1'b0) $display("FAIL lw_fault: got %b want 0", flt); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (b1.ack !== 1'b0 || b1.rdata !== 32'd0)
      $display("FAIL ack_one_cycle: got ack=%b rdata=%h want 0/0", b1.ack, b1.rdata);
    else n_pass++;
  endtask

  task automatic test_subword();
    logic [31:0] rd; logic flt; int lat;
    acc(1, 1'b0, 32'h13, 3'b000, 32'h0, rd, flt, lat);
    n_checks++;
    if (rd !== 32'hFFFFFFDE) $display("FAIL lb_13: got %h want FFFFFFDE", rd); else n_pass++;
    acc(1, 1'b0, 32'h13, 3'b100, 32'h0, rd, flt, lat);
    n_checks++;
    if (rd !== 32'h000000DE) $display("FAIL lbu_13: got %h want 000000DE", rd); else n_pass++;
    acc(1, 1'b0, 32'h12, 3'b001, 32'h0, rd, flt, lat);
    n_checks++;
    if (rd !== 32'hFFFFDEAD) $display("FAIL lh_12: got %h want FFFFDEAD", rd); else n_pass++;
    acc(1, 1'b0, 32'h10, 3'b101, 32'h0, rd, flt, lat);
    n_checks++;
    if (rd !== 32'h0000BEEF) $display("FAIL lhu_10: got %h want 0000BEEF", rd); else n_pass++;
    acc(1, 1'b1, 32'h11, 3'b000, 32'h55, rd, flt, lat);
    acc(1, 1'b0, 32'h10, 3'b010, 32'h0, rd, flt, lat);
    n_checks++;
    if (rd !== 32'hDEAD55EF) $display("FAIL sb_11: got %h want DEAD55EF", rd); else n_pass++;
  endtask

  task automatic test_faults();
    logic [31:0] rd; logic flt; int lat;
    acc(1, 1'b0, 32'h400, 3'b010, 32'h0, rd, flt, lat);
    n_checks++;
    if (flt !== 1'b1 || rd !== 32'd0 || lat !== 2)
      $display("FAIL lw_range: got fault=%b rdata=%h lat=%0d want 1/0/2", flt, rd, lat);
    else n_pass++;
    acc(1, 1'b1, 32'h10, 3'b011, 32'hFFFFFFFF, rd, flt, lat);
    n_checks++;
    if (flt !== 1'b1) $display("FAIL sw_f3_011: got fault=%b want 1", flt); else n_pass++;
    acc(1, 1'b1, 32'h10, 3'b100, 32'hFFFFFFFF, rd, flt, lat);
    n_checks++;
    if (flt !== 1'b1) $display("FAIL sbu_illegal: got fault=%b want 1", flt); else n_pass++;
    acc(1, 1'b0, 32'h10, 3'b110, 32'h0, rd, flt, lat);
    n_checks++;
    if (flt !== 1'b1 || rd !== 32'd0)
      $display("FAIL ld_f3_110: got fault=%b rdata=%h want 1/0", flt, rd);
    else n_pass++;
    acc(1, 1'b0, 32'h10, 3'b010, 32'h0, rd, flt, lat);
    n_checks++;
    if (rd !== 32'hDEAD55EF) $display("FAIL mem_unchanged: got %h want DEAD55EF", rd); else n_pass++;
  endtask

  task automatic test_align();
    logic [31:0] rd; logic flt; int lat;
    acc(1, 1'b0, 32'h12, 3'b010, 32'h0, rd, flt, lat);
`ifdef DMEM_ALIGN_CHECK_EN
    n_checks++;
    if (flt !== 1'b1 || rd !== 32'd0)
      $display("FAIL lw_12_align: got fault=%b rdata=%h want 1/0", flt, rd);
    else n_pass++;
`else
    n_checks++;
    if (flt !== 1'b0 || rd !== 32'hDEAD55EF)
      $display("FAIL lw_12_noalign: got fault=%b rdata=%h want 0/DEAD55EF", flt, rd);
    else n_pass++;
`endif
    acc(1, 1'b0, 32'h11, 3'b001, 32'h0, rd, flt, lat);
`ifdef DMEM_ALIGN_CHECK_EN
    n_checks++;
    if (flt !== 1'b1) $display("FAIL lh_11_align: got fault=%b want 1", flt); else n_pass++;
`else
    n_checks++;
    if (flt !== 1'b0 || rd !== 32'h000055EF)
      $display("FAIL lh_11_noalign: got fault=%b rdata=%h want 0/000055EF", flt, rd);
    else n_pass++;
`endif
  endtask

  task automatic test_store_half();
    logic [31:0] rd; logic flt; int lat;
    acc(1, 1'b1, 32'h12, 3'b001, 32'hFFFFCAFE, rd, flt, lat);
    acc(1, 1'b0, 32'h10, 3'b010, 32'h0, rd, flt, lat);
    n_checks++;
    if (rd !== 32'hCAFE55EF) $display("FAIL sh_12: got %h want CAFE55EF", rd); else n_pass++;
    acc(1, 1'b0, 32'h12, 3'b001, 32'h0, rd, flt, lat);
    n_checks++;
    if (rd !== 32'hFFFFCAFE) $display("FAIL lh_12_after_sh: got %h want FFFFCAFE", rd); else n_pass++;
  endtask

  task automatic test_wait_reset();
    logic [31:0] rd; logic flt; int lat; int acks;
    acc(3, 1'b1, 32'h20, 3'b010, 32'hA5A5A5A5, rd, flt, lat);
    n_checks++;
    if (lat !== 4) $display("FAIL ws3_latency: got %0d want 4", lat); else n_pass++;
    @(negedge clk);
    b3.req = 1'b1; b3.we = 1'b1; b3.addr = 32'h20; b3.funct3 = 3'b010;
    b3.wdata = 32'h12345678;
    @(negedge clk);
    rst3 = 1'b1;
    b3.req = 1'b0;
    @(negedge clk);
    rst3 = 1'b0;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b3.ack === 1'b1) acks++;
    end
    n_checks++;
    if (acks !== 0) $display("FAIL rst_in_wait_ack: got %0d acks want 0", acks); else n_pass++;
    acc(3, 1'b0, 32'h20, 3'b010, 32'h0, rd, flt, lat);
    n_checks++;
    if (rd !== 32'hA5A5A5A5) $display("FAIL rst_in_wait_mem: got %h want A5A5A5A5", rd); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic        wv [3];
    logic [31:0] av [3];
    logic [31:0] dv [3];
    logic [31:0] rd_got [3];
    logic        flt_got [3];
    int          gap_bad;
    int          acks;
    int          last;
    wv = '{1'b1, 1'b0, 1'b0};
    av = '{32'h24, 32'h24, 32'h20};
    dv = '{32'h11112222, 32'h0, 32'h0};
    for (int i = 0; i < 3; i++) begin
      rd_got[i] = 'x;
      flt_got[i] = 1'bx;
    end
    gap_bad = 0; acks = 0; last = -1;
    @(negedge clk);
    b3.req = 1'b1; b3.we = wv[0]; b3.addr = av[0]; b3.funct3 = 3'b010; b3.wdata = dv[0];
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (b3.ack === 1'b1) begin
        if (acks < 3) begin
          rd_got[acks] = b3.rdata;
          flt_got[acks] = b3.fault;
        end
        if (acks == 0 && cyc != 3) gap_bad++;
        if (acks > 0 && cyc - last != 5) gap_bad++;
        acks++;
        last = cyc;
        if (acks < 3) begin
          b3.we = wv[acks]; b3.addr = av[acks]; b3.wdata = dv[acks];
        end else begin
          b3.req = 1'b0;
        end
      end
    end
    b3.req = 1'b0;
    n_checks++;
    if (acks !== 3) $display("FAIL b2b_ack_count: got %0d want 3", acks); else n_pass++;
    n_checks++;
    if (gap_bad !== 0) $display("FAIL b2b_spacing: got %0d bad gaps want 0", gap_bad); else n_pass++;
    n_checks++;
    if (rd_got[1] !== 32'h11112222) $display("FAIL b2b_load1: got %h want 11112222", rd_got[1]);
    else n_pass++;
    n_checks++;
    if (rd_got[2] !== 32'hA5A5A5A5) $display("FAIL b2b_load2: got %h want A5A5A5A5", rd_got[2]);
    else n_pass++;
    n_checks++;
    if (flt_got[0] !== 1'b0 || flt_got[1] !== 1'b0 || flt_got[2] !== 1'b0)
      $display("FAIL b2b_fault: got %b%b%b want 000", flt_got[0], flt_got[1], flt_got[2]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_faults();
    test_align();
    test_store_half();
    test_wait_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
